counter_sequencer: RTL and testbench

Command-driven controller for the 16-bit synchronous counter (MODO 00 up, 01 down, 10 down-by-3, 11 parallel load; ENB gate; RCO carry).
Accepts one command per valid/ready handshake, optionally preloads the counter, then enables it for exactly STEPS clocks.
Captures the final Q and the number of RCO events, and reports completion with a one-cycle DONE pulse.
Sits between test/control logic and the counter instance; it is the sole driver of the counter's D, MODO and ENB.

---
 rtl/counter_seq_pkg.sv | 17 +
 rtl/seq_step_counter.sv | 34 +++
 rtl/counter_sequencer.sv | 128 ++++++++++++
 tb/tb_counter_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and counter mode encodings for the counter sequencer.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StSettle,
    StDone
  } seq_state_e;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

endpackage

// File: rtl/seq_step_counter.sv
// Down-counter that times the RUN phase; last_o flags the final enabled cycle.
module seq_step_counter #(
  parameter int unsigned StepW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [StepW-1:0] value_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [StepW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - StepW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == StepW'(1));

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller: optional preload, STEPS enabled count clocks,
// then captures final Q and RCO event count and pulses done.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned StepW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_modo_i,
  input  logic             cmd_load_i,
  input  logic [Width-1:0] cmd_d_i,
  input  logic [StepW-1:0] cmd_steps_i,
  input  logic             abort_i,
  output logic             enb_o,
  output logic [1:0]       modo_o,
  output logic [Width-1:0] d_o,
  input  logic [Width-1:0] q_i,
  input  logic             rco_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [Width-1:0] q_final_o,
  output logic [StepW-1:0] rco_count_o
);

  seq_state_e       state_q, state_d;
  logic [1:0]       mode_q, mode_d, modo_q, modo_d;
  logic             run_after_load_q, run_after_load_d;
  logic             enb_q, enb_d, first_q, first_d, aborted_q, aborted_d;
  logic [Width-1:0] d_q, d_d, q_final_q, q_final_d;
  logic [StepW-1:0] rco_cnt_q, rco_cnt_d;
  logic             accept, abort_ok, rco_sample, step_load, step_last;

  seq_step_counter #(
    .StepW (StepW)
  ) u_step (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (step_load),
    .value_i (cmd_steps_i),
    .dec_i   (state_q == StRun),
    .last_o  (step_last)
  );

  assign accept    = cmd_valid_i && (state_q == StIdle);
  assign step_load = accept;
  assign abort_ok  = abort_i && ((state_q == StLoad) || (state_q == StRun));

  always_comb begin
    state_d          = state_q;
    mode_d           = accept ? cmd_modo_i : mode_q;
    run_after_load_d = accept ? ((cmd_modo_i != MODO_LOAD) && (cmd_steps_i != '0))
                              : run_after_load_q;
    d_d              = accept ? cmd_d_i : d_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_load_i || (cmd_modo_i == MODO_LOAD)) state_d = StLoad;
          else if (cmd_steps_i != '0)                  state_d = StRun;
          else                                         state_d = StSettle;
        end
      end
      StLoad:   state_d = (abort_i || !run_after_load_q) ? StSettle : StRun;
      StRun:    state_d = (abort_i || step_last) ? StSettle : StRun;
      StSettle: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Counter controls are registered from the next state so they line up with it.
    enb_d  = (state_d == StLoad) || (state_d == StRun);
    modo_d = (state_d == StLoad) ? MODO_LOAD : (state_d == StRun) ? mode_d : MODO_UP;
    first_d = (state_d == StRun) && (state_q != StRun);

    // The first RUN edge still shows pre-step Q, so it is skipped; SETTLE exit covers the last.
    rco_sample = ((state_q == StRun) && !first_q) || (state_q == StSettle);
    rco_cnt_d  = rco_cnt_q;
    if (accept) begin
      rco_cnt_d = '0;
    end else if (rco_sample && rco_i && (rco_cnt_q != '1)) begin
      rco_cnt_d = rco_cnt_q + StepW'(1);
    end

    aborted_d = accept ? 1'b0 : (aborted_q || abort_ok);
    q_final_d = (state_q == StSettle) ? q_i : q_final_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      mode_q           <= MODO_UP;
      run_after_load_q <= 1'b0;
      enb_q            <= 1'b0;
      modo_q           <= MODO_UP;
      d_q              <= '0;
      first_q          <= 1'b0;
      aborted_q        <= 1'b0;
      q_final_q        <= '0;
      rco_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      run_after_load_q <= run_after_load_d;
      enb_q            <= enb_d;
      modo_q           <= modo_d;
      d_q              <= d_d;
      first_q          <= first_d;
      aborted_q        <= aborted_d;
      q_final_q        <= q_final_d;
      rco_cnt_q        <= rco_cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign enb_o       = enb_q;
  assign modo_o      = modo_q;
  assign d_o         = d_q;
  assign aborted_o   = aborted_q;
  assign q_final_o   = q_final_q;
  assign rco_count_o = rco_cnt_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: behavioural 16-bit counter plus arithmetic reference model.
module tb_counter_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_load, abort;
  logic [1:0]  cmd_modo, modo;
  logic [15:0] cmd_d, d, q_final;
  logic [7:0]  cmd_steps, rco_count;
  logic        enb, busy, done, aborted, rco;

  logic [15:0] q_cnt = 16'h1234;
  logic [1:0]  cur_mode = 2'b00;
  logic        rco_force = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  counter_sequencer #(
    .Width (16),
    .StepW (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_modo_i  (cmd_modo),
    .cmd_load_i  (cmd_load),
    .cmd_d_i     (cmd_d),
    .cmd_steps_i (cmd_steps),
    .abort_i     (abort),
    .enb_o       (enb),
    .modo_o      (modo),
    .d_o         (d),
    .q_i         (q_cnt),
    .rco_i       (rco),
    .busy_o      (busy),
    .done_o      (done),
    .aborted_o   (aborted),
    .q_final_o   (q_final),
    .rco_count_o (rco_count)
  );

  // Environment: the counter being driven.
  always @(posedge clk) begin
    if (enb) begin
      case (modo)
        2'b00:   q_cnt <= q_cnt + 16'd1;
        2'b01:   q_cnt <= q_cnt - 16'd1;
        2'b10:   q_cnt <= q_cnt - 16'd3;
        default: q_cnt <= d;
      endcase
    end
  end

  function automatic logic rco_of(input logic [15:0] q, input logic [1:0] m);
    if (rco_force) return 1'b1;
    return (m == 2'b00 || m == 2'b11) ? (q == 16'hFFFF) : (q == 16'h0000);
  endfunction

  assign rco = rco_of(q_cnt, cur_mode);

  function automatic logic [15:0] q_after(input logic [15:0] q0, input logic [1:0] m, input int j);
    case (m)
      2'b00:   return q0 + 16'(j);
      2'b01:   return q0 - 16'(j);
      2'b10:   return q0 - 16'(3 * j);
      default: return q0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ab = edge index after accept at which ABORT is sampled (0 = none).
  task automatic run_cmd(input bit ld, input logic [1:0] m, input logic [15:0] v, input int s,
                         input int ab, input bit b2b);
    int L, se, n, exp_done, rc, w, e;
    bit eff;
    logic [15:0] q0, qf;
    cur_mode  = m;
    cmd_load  = ld;
    cmd_modo  = m;
    cmd_d     = v;
    cmd_steps = 8'(s);
    cmd_valid = 1'b1;
    for (w = 0; w < 50; w++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("accept_wait", (w < 50), 1);
    if (w >= 50) begin
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept", w, 1);
    q0 = q_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_d     = 16'($urandom);
    cmd_modo  = 2'($urandom);
    cmd_steps = 8'($urandom);
    cmd_load  = 1'($urandom);

    L  = (ld || m == 2'b11) ? 1 : 0;
    se = (m == 2'b11) ? 0 : s;
    eff = (ab >= 1) && (ab <= L + se);
    if (eff) begin
      n = (ab > L) ? ab - L : 0;
      exp_done = ab + 1;
    end else begin
      n = se;
      exp_done = L + se + 1;
    end
    if (L == 1) q0 = v;
    qf = q_after(q0, m, n);
    rc = 0;
    if (n == 0) rc = rco_of(q0, m);
    for (int j = 1; j <= n; j++) rc += rco_of(q_after(q0, m, j), m);
    if (rc > 255) rc = 255;

    check("acc_enb", enb, (L == 1 || se > 0));
    check("acc_modo", modo, (L == 1) ? 2'b11 : (se > 0) ? m : 2'b00);
    if (L == 1) check("acc_d", d, v);

    for (e = 1; e <= exp_done + 5; e++) begin
      abort = (e == ab);
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (eff && e == ab) check("abort_enb", enb, 0);
      if (done) break;
    end
    check("done_latency", e, exp_done);
    check("q_final", q_final, qf);
    check("rco_count", rco_count, rc);
    check("aborted", aborted, eff);
    check("ready_in_done", cmd_ready, 0);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_modo = 2'b00;
    cmd_d = '0;
    cmd_steps = '0;
    abort = 1'b0;
    #3;
    check("rst_enb", enb, 0);
    check("rst_modo", modo, 0);
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_qfinal", q_final, 0);
    check("rst_rco", rco_count, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmd(1, 2'b00, 16'h0000, 5, 0, 0);
    run_cmd(1, 2'b00, 16'hFFFD, 4, 0, 1);
    run_cmd(1, 2'b01, 16'h0002, 4, 0, 1);
    run_cmd(1, 2'b10, 16'h0009, 4, 0, 1);
    run_cmd(1, 2'b00, 16'h0000, 200, 10, 1);
    run_cmd(0, 2'b11, 16'h5555, 7, 0, 1);
    run_cmd(0, 2'b00, 16'h0000, 0, 0, 1);
    run_cmd(0, 2'b01, 16'h0000, 6, 0, 1);
    run_cmd(1, 2'b01, 16'h0010, 5, 1, 1);
    run_cmd(0, 2'b00, 16'h0000, 3, 1, 1);
    rco_force = 1'b1;
    run_cmd(1, 2'b00, 16'h0000, 255, 0, 1);
    rco_force = 1'b0;

    // Reset in the middle of a run.
    cur_mode = 2'b01;
    cmd_load = 1'b0;
    cmd_modo = 2'b01;
    cmd_d = 16'hABCD;
    cmd_steps = 8'd50;
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_enb", enb, 0);
    check("midrst_modo", modo, 0);
    check("midrst_d", d, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run_cmd(1, 2'b00, 16'h0100, 3, 0, 0);
    run_cmd(0, 2'b01, 16'h0000, 2, 0, 1);

    for (int i = 0; i < 25; i++) begin
      int s, ab;
      s  = int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, s + 3)) : 0;
      run_cmd(1'($urandom), 2'($urandom), 16'($urandom), s, ab, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
